// File: rtl/chacha_pkg.sv
// Shared types and constants for the ChaCha keystream core.
package chacha_pkg;

  // Sixteen 32-bit state words; word i occupies bits [32i +: 32].
  typedef logic [15:0][31:0] state_t;

  // "expand 32-byte k" in little-endian words; element 0 is word 0.
  localparam logic [3:0][31:0] Sigma = {
    32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865
  };

  // Word indices feeding quarter-round lane [l], operand slot [s] (a, b, c, d).
  localparam logic [3:0] ColIdx [4][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15}
  };

  localparam logic [3:0] DiagIdx [4][4] = '{
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };

  typedef enum logic [1:0] {
    StIdle,
    StRound,
    StHold
  } fsm_e;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/chacha_qr.sv
// Combinational ChaCha quarter round.
module chacha_qr
  import chacha_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] a_new,
  output logic [31:0] b_new,
  output logic [31:0] c_new,
  output logic [31:0] d_new
);

  logic [31:0] a1, b1, c1, d1;

  // Two add/xor/rotate half-steps; the second half feeds the outputs.
  always_comb begin
    a1    = a + b;
    d1    = rotl32(d ^ a1, 16);
    c1    = c + d1;
    b1    = rotl32(b ^ c1, 12);
    a_new = a1 + b1;
    d_new = rotl32(d1 ^ a_new, 8);
    c_new = c1 + d_new;
    b_new = rotl32(b1 ^ c_new, 7);
  end

endmodule

// File: rtl/chacha_stream_core.sv
// ChaCha keystream generator: one round per cycle, auto-incrementing block counter,
// valid/ready config and keystream ports.
module chacha_stream_core
  import chacha_pkg::*;
#(
  parameter int unsigned ROUNDS = 20,
  parameter int unsigned CTR_W  = 32,
  localparam int unsigned NONCE_W = 128 - CTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [255:0]       key,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [CTR_W-1:0]   ctr_init,
  input  logic [15:0]        nblocks,
  input  logic               abort,
  output logic               ks_valid,
  input  logic               ks_ready,
  output logic [511:0]       ks_data,
  output logic [CTR_W-1:0]   ks_ctr,
  output logic               ks_last,
  output logic               busy,
  output logic               ctr_wrap
);

  localparam int unsigned CtrWords = CTR_W / 32;
  localparam int unsigned RndW     = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;

  if ((ROUNDS < 2) || ((ROUNDS % 2) != 0)) begin : g_bad_rounds
    $error("chacha_stream_core: ROUNDS must be even and at least 2");
  end
  if ((CTR_W != 32) && (CTR_W != 64)) begin : g_bad_ctr_w
    $error("chacha_stream_core: CTR_W must be 32 or 64");
  end

  fsm_e                state_q, state_d;
  state_t              work_q, work_d;
  state_t              init_q, init_d;
  logic [RndW-1:0]     round_q, round_d;
  logic [CTR_W-1:0]    ctr_q, ctr_d, ctr_inc;
  logic [15:0]         remain_q, remain_d;
  logic [511:0]        ks_data_q, ks_data_d;
  logic [CTR_W-1:0]    ks_ctr_q, ks_ctr_d;
  logic                ks_last_q, ks_last_d;
  logic                ctr_wrap_q, ctr_wrap_d;

  logic                diag_rnd;
  logic [31:0]         qr_in    [4][4];
  logic [31:0]         qr_out   [4][4];
  logic [31:0]         col_res  [16];
  logic [31:0]         diag_res [16];
  state_t              round_out;
  state_t              ks_sum;

  function automatic state_t with_ctr(input state_t s, input logic [CTR_W-1:0] c);
    state_t r;
    r = s;
    r[12+CtrWords-1:12] = c;
    return r;
  endfunction

  function automatic state_t initial_state(input logic [255:0]       k,
                                           input logic [NONCE_W-1:0] n,
                                           input logic [CTR_W-1:0]   c);
    state_t r;
    r                   = '0;
    r[3:0]              = Sigma;
    r[11:4]             = k;
    r[15:12+CtrWords]   = n;
    return with_ctr(r, c);
  endfunction

  // Even rounds mix columns, odd rounds mix diagonals.
  assign diag_rnd = round_q[0];

  for (genvar l = 0; l < 4; l++) begin : g_lane
    for (genvar s = 0; s < 4; s++) begin : g_slot
      assign qr_in[l][s]               = diag_rnd ? work_q[DiagIdx[l][s]] : work_q[ColIdx[l][s]];
      assign col_res[ColIdx[l][s]]     = qr_out[l][s];
      assign diag_res[DiagIdx[l][s]]   = qr_out[l][s];
    end

    chacha_qr u_qr (
      .a     (qr_in[l][0]),
      .b     (qr_in[l][1]),
      .c     (qr_in[l][2]),
      .d     (qr_in[l][3]),
      .a_new (qr_out[l][0]),
      .b_new (qr_out[l][1]),
      .c_new (qr_out[l][2]),
      .d_new (qr_out[l][3])
    );
  end

  for (genvar i = 0; i < 16; i++) begin : g_word
    assign round_out[i] = diag_rnd ? diag_res[i] : col_res[i];
    // Feed-forward of the initial state, per word mod 2^32.
    assign ks_sum[i]    = round_out[i] + init_q[i];
  end

  // Next-state logic for the run sequencing and the output block register.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    init_d     = init_q;
    round_d    = round_q;
    ctr_d      = ctr_q;
    remain_d   = remain_q;
    ks_data_d  = ks_data_q;
    ks_ctr_d   = ks_ctr_q;
    ks_last_d  = ks_last_q;
    ctr_wrap_d = ctr_wrap_q;
    ctr_inc    = ctr_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        if (cfg_valid) begin
          init_d     = initial_state(key, nonce, ctr_init);
          work_d     = init_d;
          round_d    = '0;
          ctr_d      = ctr_init;
          remain_d   = nblocks;
          ctr_wrap_d = 1'b0;
          state_d    = StRound;
        end
      end

      StRound: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          work_d = round_out;
          if (round_q == RndW'(ROUNDS - 1)) begin
            ks_data_d = ks_sum;
            ks_ctr_d  = ctr_q;
            // All-ones counter ends the run so no counter value is ever reused.
            ks_last_d = (remain_q == 16'd1) || (&ctr_q);
            state_d   = StHold;
          end else begin
            round_d = round_q + 1'b1;
          end
        end
      end

      StHold: begin
        if (ks_ready) begin
          if (ks_last_q) begin
            state_d = StIdle;
            if (&ctr_q) begin
              ctr_wrap_d = 1'b1;
            end
          end else if (abort) begin
            // The block just accepted still counts; nothing further is produced.
            state_d = StIdle;
          end else begin
            ctr_d   = ctr_inc;
            // remain_q of zero marks a continuous run and is never decremented.
            if (remain_q != 16'd0) begin
              remain_d = remain_q - 16'd1;
            end
            init_d  = with_ctr(init_q, ctr_inc);
            work_d  = init_d;
            round_d = '0;
            state_d = StRound;
          end
        end else if (abort) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      work_q     <= '0;
      init_q     <= '0;
      round_q    <= '0;
      ctr_q      <= '0;
      remain_q   <= '0;
      ks_data_q  <= '0;
      ks_ctr_q   <= '0;
      ks_last_q  <= 1'b0;
      ctr_wrap_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      init_q     <= init_d;
      round_q    <= round_d;
      ctr_q      <= ctr_d;
      remain_q   <= remain_d;
      ks_data_q  <= ks_data_d;
      ks_ctr_q   <= ks_ctr_d;
      ks_last_q  <= ks_last_d;
      ctr_wrap_q <= ctr_wrap_d;
    end
  end

  assign cfg_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign ks_valid  = (state_q == StHold);
  assign ks_data   = ks_data_q;
  assign ks_ctr    = ks_ctr_q;
  assign ks_last   = ks_last_q;
  assign ctr_wrap  = ctr_wrap_q;

endmodule

// File: tb/tb_chacha_stream_core.sv
// Directed bench for chacha_stream_core: RFC 8439 block vector, backpressure, counter wrap,
// reduced-round 64-bit-counter profiles, abort and mid-run reset.
module tb_chacha_stream_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, abort, ks_ready;
  logic         cfg_valid20, cfg_valid8, cfg_valid12;
  logic [255:0] key;
  logic [95:0]  nonce96;
  logic [31:0]  ctr32;
  logic [63:0]  nonce64, ctr64;
  logic [15:0]  nblocks;

  logic         cfg_ready20, ks_valid20, ks_last20, busy20, wrap20;
  logic [511:0] ks_data20;
  logic [31:0]  ks_ctr20;
  logic         cfg_ready8, ks_valid8, ks_last8, busy8, wrap8;
  logic [511:0] ks_data8;
  logic [63:0]  ks_ctr8;
  logic         cfg_ready12, ks_valid12, ks_last12, busy12, wrap12;
  logic [511:0] ks_data12;
  logic [63:0]  ks_ctr12;

  int n_vec;
  int n_err;

  chacha_stream_core #(.ROUNDS(20), .CTR_W(32)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid20), .cfg_ready(cfg_ready20), .key(key),
    .nonce(nonce96), .ctr_init(ctr32), .nblocks(nblocks), .abort(abort),
    .ks_valid(ks_valid20), .ks_ready(ks_ready), .ks_data(ks_data20), .ks_ctr(ks_ctr20),
    .ks_last(ks_last20), .busy(busy20), .ctr_wrap(wrap20)
  );

  chacha_stream_core #(.ROUNDS(8), .CTR_W(64)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid8), .cfg_ready(cfg_ready8), .key(key),
    .nonce(nonce64), .ctr_init(ctr64), .nblocks(nblocks), .abort(abort),
    .ks_valid(ks_valid8), .ks_ready(ks_ready), .ks_data(ks_data8), .ks_ctr(ks_ctr8),
    .ks_last(ks_last8), .busy(busy8), .ctr_wrap(wrap8)
  );

  chacha_stream_core #(.ROUNDS(12), .CTR_W(64)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid12), .cfg_ready(cfg_ready12), .key(key),
    .nonce(nonce64), .ctr_init(ctr64), .nblocks(nblocks), .abort(abort),
    .ks_valid(ks_valid12), .ks_ready(ks_ready), .ks_data(ks_data12), .ks_ctr(ks_ctr12),
    .ks_last(ks_last12), .busy(busy12), .ctr_wrap(wrap12)
  );

  // View of whichever 64-bit-counter instance is under test.
  int           sel_r = 8;
  logic         v64, last64, busy64, rdy64;
  logic [511:0] data64;
  logic [63:0]  ctr_o64;
  assign v64     = (sel_r == 8) ? ks_valid8  : ks_valid12;
  assign last64  = (sel_r == 8) ? ks_last8   : ks_last12;
  assign busy64  = (sel_r == 8) ? busy8      : busy12;
  assign rdy64   = (sel_r == 8) ? cfg_ready8 : cfg_ready12;
  assign data64  = (sel_r == 8) ? ks_data8   : ks_data12;
  assign ctr_o64 = (sel_r == 8) ? ks_ctr8    : ks_ctr12;

  // Textbook reference: double rounds of four column then four diagonal quarter rounds.
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [15:0][31:0] qr_m(input logic [15:0][31:0] x, input logic [3:0] ia,
                                             input logic [3:0] ib, input logic [3:0] ic,
                                             input logic [3:0] id);
    logic [31:0] a, b, c, d;
    a = x[ia]; b = x[ib]; c = x[ic]; d = x[id];
    a = a + b; d = rl(d ^ a, 16);
    c = c + d; b = rl(b ^ c, 12);
    a = a + b; d = rl(d ^ a, 8);
    c = c + d; b = rl(b ^ c, 7);
    x[ia] = a; x[ib] = b; x[ic] = c; x[id] = d;
    return x;
  endfunction

  function automatic logic [511:0] ref_block(input int rounds, input logic [255:0] k,
                                             input logic [127:0] tail);
    logic [15:0][31:0] s, x;
    s = {tail, k, 128'h6b206574_79622d32_3320646e_61707865};
    x = s;
    for (int i = 0; i < rounds / 2; i++) begin
      x = qr_m(x, 4'd0, 4'd4, 4'd8,  4'd12);
      x = qr_m(x, 4'd1, 4'd5, 4'd9,  4'd13);
      x = qr_m(x, 4'd2, 4'd6, 4'd10, 4'd14);
      x = qr_m(x, 4'd3, 4'd7, 4'd11, 4'd15);
      x = qr_m(x, 4'd0, 4'd5, 4'd10, 4'd15);
      x = qr_m(x, 4'd1, 4'd6, 4'd11, 4'd12);
      x = qr_m(x, 4'd2, 4'd7, 4'd8,  4'd13);
      x = qr_m(x, 4'd3, 4'd4, 4'd9,  4'd14);
    end
    for (int i = 0; i < 16; i++) x[i[3:0]] = x[i[3:0]] + s[i[3:0]];
    return x;
  endfunction

  task automatic cfg20(input logic [31:0] c, input logic [15:0] nb);
    ctr32 = c; nblocks = nb; cfg_valid20 = 1'b1;
    @(negedge clk);
    cfg_valid20 = 1'b0;
  endtask

  task automatic wait_valid20(output int cycles);
    cycles = 0;
    while (!ks_valid20 && cycles < 200) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if ({cfg_ready20, ks_valid20, ks_last20, busy20, wrap20} !== 5'b10000) begin
      n_err++;
      $display("FAIL reset_ctl20: got %b want 10000",
               {cfg_ready20, ks_valid20, ks_last20, busy20, wrap20});
    end
    n_vec++;
    if (ks_data20 !== 512'd0) begin
      n_err++; $display("FAIL reset_data20: got %h want 0", ks_data20);
    end
    n_vec++;
    if (ks_ctr20 !== 32'd0) begin
      n_err++; $display("FAIL reset_ctr20: got %h want 0", ks_ctr20);
    end
    n_vec++;
    if ({cfg_ready8, ks_valid8, busy8, cfg_ready12, ks_valid12, busy12} !== 6'b100100) begin
      n_err++;
      $display("FAIL reset_ctl64: got %b want 100100",
               {cfg_ready8, ks_valid8, busy8, cfg_ready12, ks_valid12, busy12});
    end
  endtask

  task automatic test_rfc_single();
    int lat;
    nonce96 = {32'h00000000, 32'h4a000000, 32'h09000000};
    cfg20(32'd1, 16'd1);
    n_vec++;
    if (busy20 !== 1'b1) begin n_err++; $display("FAIL rfc_busy: got %b want 1", busy20); end
    wait_valid20(lat);
    n_vec++;
    if (ks_valid20 !== 1'b1 || lat != 20) begin
      n_err++; $display("FAIL rfc_latency: got %0d (valid %b) want 20", lat, ks_valid20);
    end
    n_vec++;
    if (ks_data20[31:0] !== 32'he4e7f110) begin
      n_err++; $display("FAIL rfc_word0: got %h want e4e7f110", ks_data20[31:0]);
    end
    n_vec++;
    if (ks_data20[511:480] !== 32'h4e3c50a2) begin
      n_err++; $display("FAIL rfc_word15: got %h want 4e3c50a2", ks_data20[511:480]);
    end
    n_vec++;
    if (ks_data20 !== ref_block(20, key, {nonce96, 32'd1})) begin
      n_err++; $display("FAIL rfc_block: got %h", ks_data20);
    end
    n_vec++;
    if ({ks_last20, ks_ctr20} !== {1'b1, 32'd1}) begin
      n_err++; $display("FAIL rfc_last_ctr: got %b/%h want 1/00000001", ks_last20, ks_ctr20);
    end
    ks_ready = 1'b1;
    @(negedge clk);
    ks_ready = 1'b0;
    n_vec++;
    if ({ks_valid20, busy20, cfg_ready20} !== 3'b001) begin
      n_err++; $display("FAIL rfc_done: got %b want 001", {ks_valid20, busy20, cfg_ready20});
    end
  endtask

  task automatic test_backpressure();
    int w, stall;
    logic hs;
    logic [511:0] held;
    cfg20(32'd1, 16'd3);
    for (int b = 0; b < 3; b++) begin
      wait_valid20(w);
      n_vec++;
      if (ks_valid20 !== 1'b1) begin
        n_err++; $display("FAIL bp_valid blk%0d: got %b want 1", b, ks_valid20);
      end
      held = ks_data20;
      n_vec++;
      if (ks_ctr20 !== 32'(b + 1)) begin
        n_err++; $display("FAIL bp_ctr blk%0d: got %h want %h", b, ks_ctr20, 32'(b + 1));
      end
      n_vec++;
      if (ks_last20 !== (b == 2)) begin
        n_err++; $display("FAIL bp_last blk%0d: got %b want %b", b, ks_last20, (b == 2));
      end
      n_vec++;
      if (ks_data20 !== ref_block(20, key, {nonce96, 32'(b + 1)})) begin
        n_err++; $display("FAIL bp_data blk%0d: got %h", b, ks_data20);
      end
      stall = 0;
      forever begin
        ks_ready = ((stall >= 1) && ($urandom_range(0, 1) == 1)) || (stall >= 4);
        hs = ks_ready;
        @(negedge clk);
        if (hs) break;
        stall++;
        n_vec++;
        if ({ks_valid20, ks_data20} !== {1'b1, held}) begin
          n_err++; $display("FAIL bp_stable blk%0d: valid %b data %h", b, ks_valid20, ks_data20);
        end
      end
      ks_ready = 1'b0;
    end
    n_vec++;
    if ({busy20, cfg_ready20} !== 2'b01) begin
      n_err++; $display("FAIL bp_idle: got %b want 01", {busy20, cfg_ready20});
    end
  endtask

  task automatic test_wrap();
    int w;
    logic seen;
    cfg20(32'hffff_fffe, 16'd0);
    wait_valid20(w);
    n_vec++;
    if ({ks_valid20, ks_last20, ks_ctr20} !== {2'b10, 32'hffff_fffe}) begin
      n_err++; $display("FAIL wrap_blk0: got %b/%b/%h want 1/0/fffffffe",
                        ks_valid20, ks_last20, ks_ctr20);
    end
    ks_ready = 1'b1;
    @(negedge clk);
    ks_ready = 1'b0;
    wait_valid20(w);
    n_vec++;
    if ({ks_valid20, ks_last20, wrap20, ks_ctr20} !== {3'b110, 32'hffff_ffff}) begin
      n_err++; $display("FAIL wrap_blk1: got %b/%b/%b/%h want 1/1/0/ffffffff",
                        ks_valid20, ks_last20, wrap20, ks_ctr20);
    end
    n_vec++;
    if (ks_data20 !== ref_block(20, key, {nonce96, 32'hffff_ffff})) begin
      n_err++; $display("FAIL wrap_data: got %h", ks_data20);
    end
    ks_ready = 1'b1;
    @(negedge clk);
    ks_ready = 1'b0;
    n_vec++;
    if ({busy20, wrap20} !== 2'b01) begin
      n_err++; $display("FAIL wrap_sticky: got busy/wrap %b want 01", {busy20, wrap20});
    end
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (ks_valid20) seen = 1'b1;
    end
    n_vec++;
    if (seen !== 1'b0 || wrap20 !== 1'b1) begin
      n_err++; $display("FAIL wrap_no_repeat: valid seen %b wrap %b want 0/1", seen, wrap20);
    end
    cfg20(32'h10, 16'd1);
    n_vec++;
    if ({busy20, wrap20} !== 2'b10) begin
      n_err++; $display("FAIL wrap_clear: got busy/wrap %b want 10", {busy20, wrap20});
    end
    wait_valid20(w);
    ks_ready = 1'b1;
    @(negedge clk);
    ks_ready = 1'b0;
  endtask

  task automatic test_rounds64(input int r);
    int lat, p;
    sel_r   = r;
    ctr64   = 64'h0000_0005_ffff_ffff;
    nonce64 = 64'hdead_beef_0123_4567;
    nblocks = 16'd2;
    @(negedge clk);
    n_vec++;
    if (rdy64 !== 1'b1) begin n_err++; $display("FAIL r%0d_ready: got %b want 1", r, rdy64); end
    if (r == 8) cfg_valid8 = 1'b1; else cfg_valid12 = 1'b1;
    @(negedge clk);
    cfg_valid8 = 1'b0; cfg_valid12 = 1'b0;
    lat = 0;
    while (!v64 && lat < 200) begin @(negedge clk); lat++; end
    n_vec++;
    if (v64 !== 1'b1 || lat != r) begin
      n_err++; $display("FAIL r%0d_latency: got %0d (valid %b) want %0d", r, lat, v64, r);
    end
    n_vec++;
    if ({last64, ctr_o64} !== {1'b0, 64'h0000_0005_ffff_ffff}) begin
      n_err++; $display("FAIL r%0d_blk0_ctr: got %b/%h", r, last64, ctr_o64);
    end
    n_vec++;
    if (data64 !== ref_block(r, key, {nonce64, 64'h0000_0005_ffff_ffff})) begin
      n_err++; $display("FAIL r%0d_blk0_data: got %h", r, data64);
    end
    ks_ready = 1'b1;
    p = 0;
    do begin @(negedge clk); p++; end while (!v64 && p < 200);
    n_vec++;
    if (p != r + 1) begin
      n_err++; $display("FAIL r%0d_period: got %0d want %0d", r, p, r + 1);
    end
    n_vec++;
    if ({last64, ctr_o64} !== {1'b1, 64'h0000_0006_0000_0000}) begin
      n_err++; $display("FAIL r%0d_blk1_ctr: got %b/%h", r, last64, ctr_o64);
    end
    n_vec++;
    if (data64 !== ref_block(r, key, {nonce64, 64'h0000_0006_0000_0000})) begin
      n_err++; $display("FAIL r%0d_blk1_data: got %h", r, data64);
    end
    @(negedge clk);
    ks_ready = 1'b0;
    n_vec++;
    if ({v64, busy64, rdy64} !== 3'b001) begin
      n_err++; $display("FAIL r%0d_done: got %b want 001", r, {v64, busy64, rdy64});
    end
  endtask

  task automatic test_abort();
    int w;
    logic seen;
    // Abort while rounds are in flight.
    cfg20(32'd7, 16'd0);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_vec++;
    if ({busy20, cfg_ready20, ks_valid20} !== 3'b010) begin
      n_err++; $display("FAIL abort_round: got %b want 010", {busy20, cfg_ready20, ks_valid20});
    end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (ks_valid20) seen = 1'b1; end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL abort_round_quiet: valid seen %b", seen); end
    // Abort in HOLD together with an accepted transfer.
    cfg20(32'd7, 16'd0);
    wait_valid20(w);
    n_vec++;
    if ({ks_valid20, ks_last20} !== 2'b10) begin
      n_err++; $display("FAIL abort_hold_pre: got %b want 10", {ks_valid20, ks_last20});
    end
    ks_ready = 1'b1; abort = 1'b1;
    @(negedge clk);
    ks_ready = 1'b0; abort = 1'b0;
    n_vec++;
    if ({busy20, ks_valid20} !== 2'b00) begin
      n_err++; $display("FAIL abort_hold: got %b want 00", {busy20, ks_valid20});
    end
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (ks_valid20) seen = 1'b1; end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL abort_hold_quiet: valid seen %b", seen); end
    // Abort while idle must not block a simultaneous config.
    ctr32 = 32'd3; nblocks = 16'd1; cfg_valid20 = 1'b1; abort = 1'b1;
    @(negedge clk);
    cfg_valid20 = 1'b0;
    n_vec++;
    if (busy20 !== 1'b1) begin n_err++; $display("FAIL abort_idle: got busy %b want 1", busy20); end
    @(negedge clk);
    abort = 1'b0;
    n_vec++;
    if (busy20 !== 1'b0) begin
      n_err++; $display("FAIL abort_idle_cleanup: got busy %b want 0", busy20);
    end
  endtask

  task automatic test_reset_midrun();
    int w;
    logic seen;
    cfg20(32'd9, 16'd0);
    wait_valid20(w);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if ({cfg_ready20, ks_valid20, ks_last20, busy20, wrap20} !== 5'b10000) begin
      n_err++; $display("FAIL midrst_ctl: got %b want 10000",
                        {cfg_ready20, ks_valid20, ks_last20, busy20, wrap20});
    end
    n_vec++;
    if ({ks_data20, ks_ctr20} !== 544'd0) begin
      n_err++; $display("FAIL midrst_data: got %h/%h want 0", ks_data20, ks_ctr20);
    end
    seen = 1'b0;
    repeat (30) begin @(negedge clk); if (ks_valid20) seen = 1'b1; end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_quiet: valid seen %b", seen); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; abort = 1'b0; ks_ready = 1'b0;
    cfg_valid20 = 1'b0; cfg_valid8 = 1'b0; cfg_valid12 = 1'b0;
    key     = 256'h1f1e1d1c_1b1a1918_17161514_13121110_0f0e0d0c_0b0a0908_07060504_03020100;
    nonce96 = '0; ctr32 = '0; nonce64 = '0; ctr64 = '0; nblocks = '0;
    test_reset();
    test_rfc_single();
    test_backpressure();
    test_wrap();
    test_rounds64(8);
    test_rounds64(12);
    test_abort();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/chacha_stream_core.md
# chacha_stream_core

Parametrised ChaCha keystream generator, successor to the single-shot fixed-round `chacha` block. It loads a 256-bit key, a nonce and an initial block counter over a valid/ready config port. It then produces a run of 512-bit keystream blocks with auto-incrementing counter, and emits them over a valid/ready output port with backpressure. It sits between the RNG seeding/control logic and the keystream consumers (whitening, DRBG output FIFO).

## Interface
- `ROUNDS`, 20, number of rounds; must be even and ≥2 (8/12/20 are the supported profiles). Elaboration error otherwise.
- `CTR_W`, 32, block-counter width; 32 or 64. Nonce width is `NONCE_W = 128-CTR_W`.
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cfg_valid` in 1: config/start request.
- `cfg_ready` out 1: high only in IDLE.
- `key` in 256: word k = `key[32k+:32]` → state word 4+k.
- `nonce` in NONCE_W: word j = `nonce[32j+:32]` → state word 12+CTR_W/32+j.
- `ctr_init` in CTR_W: first block counter → state words 12 (and 13 if CTR_W=64, high half).
- `nblocks` in 16: blocks to emit; 0 = continuous until abort or counter wrap.
- `abort` in 1: terminate run.
- `ks_valid` out 1, `ks_ready` in 1: output handshake.
- `ks_data` out 512: word i = `ks_data[32i+:32]` = final state word i.
- `ks_ctr` out CTR_W: counter value used for `ks_data`.
- `ks_last` out 1: final block of the run.
- `busy` out 1: state ≠ IDLE.
- `ctr_wrap` out 1: sticky; cleared on next cfg accept.

## Operation
- State words 0–3 = sigma 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574. Layout otherwise per RFC 8439.
- FSM states: IDLE, ROUND, HOLD.
- IDLE: `cfg_ready=1`. A cfg handshake captures key, nonce, `ctr_init` and `nblocks` into registers. It loads the working state and the initial-state copy, sets round index r=0, clears `ctr_wrap`, and moves to ROUND.
- ROUND: one round per cycle using four QR lanes in parallel.
  - Even r: column round (0,4,8,12)(1,5,9,13)(2,6,10,14)(3,7,11,15).
  - Odd r: diagonal round (0,5,10,15)(1,6,11,12)(2,7,8,13)(3,4,9,14).
  - On r=ROUNDS-1: `ks_data` ← round output + initial state (per word, mod 2^32); `ks_ctr` ← current counter; `ks_last` ← (remaining==1) or (counter all-ones). Move to HOLD.
- HOLD: `ks_valid=1`; data is stable until accepted. On `ks_valid & ks_ready`:
  - If `ks_last`: go to IDLE. If the counter was all-ones, set `ctr_wrap`.
  - Otherwise: counter +1 (mod 2^CTR_W), remaining −1 (not decremented when nblocks=0), reload working/initial state with the new counter, r=0, go to ROUND.
- Abort while busy: next state IDLE, `ks_valid` low next cycle, and no further blocks. If abort coincides with a completing handshake, the transfer counts. Abort in IDLE is ignored. Abort has priority over cfg in the same cycle only when busy (cfg is not accepted while busy).
- Counter wrap: the block whose counter is all-ones is always `ks_last` regardless of `nblocks`. No block with a repeated counter is ever emitted.

## Timing
- Reset (`rst_n=0` at an edge): state IDLE, `ks_valid=0`, `ks_data=0`, `ks_ctr=0`, `ks_last=0`, `busy=0`, `ctr_wrap=0`. `cfg_ready=1` from the first cycle after reset.
- Reset mid-run discards the run and any pending output.
- Cfg accepted at edge T → `ks_valid` rises after edge T+ROUNDS (latency ROUNDS+1 cycles).
- With `ks_ready` held high, block period is ROUNDS+1 cycles.
- `ks_valid` never drops without a handshake, except on abort or reset.

## Structure
- Package `chacha_pkg`: SIGMA constants, state array typedef (16×32), column/diagonal index tables, FSM state enum.
- Sub-module `chacha_qr`: combinational quarter round (a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7). Instantiated 4× with column/diagonal input muxing in the core.

## Test plan
- RFC 8439 §2.3.2: key 0x00..0x1f bytes, nonce words {0x09000000, 0x4a000000, 0x00000000}, ctr_init=1, ROUNDS=20, nblocks=1 → word0=0xe4e7f110, word15=0x4e3c50a2, `ks_last=1`, `ks_valid` 21 cycles after accept.
- Same key/nonce, nblocks=3, `ks_ready` toggled randomly → `ks_ctr` = 1,2,3, data matches the C model, data stable while stalled, `ks_last` only on the third block.
- ctr_init=0xFFFFFFFE, nblocks=0 (CTR_W=32) → two blocks, second has `ks_last=1`; `ctr_wrap=1` after its handshake; a new cfg accept clears it.
- ROUNDS=8 and ROUNDS=12, CTR_W=64 → blocks match the reference model; latency 9 and 13 cycles.
- Abort mid-ROUND, abort in HOLD coinciding with handshake, and `rst_n=0` mid-run → IDLE next cycle; no further `ks_valid`; outputs at reset values after reset.
